// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the access-size encodings, the default memory size and a helper
// that turns a size code into a byte count.
package dmem_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int MEM_BYTES_DEF = 4096;

  // Bytes touched by an access; the reserved code 11 touches nothing.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (pipeline = port 0, debug/loader =
// port 1), the arbiter and the byte-addressed data memory.
//   pN_req/we/size/uns/addr/wdata : request side, driven by requester N
//   pN_gnt/rvalid/rdata/err       : grant and one-cycle-later response
//   mem_a/mem_wea/mem_wd          : word address, lane strobes, lane data
//   mem_rd                        : combinational read data for mem_a
// modport slave  : the arbiter view
// modport master : the requester/memory view (used by the bench)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              p0_req, p1_req;
  logic              p0_we, p1_we;
  logic [1:0]        p0_size, p1_size;
  logic              p0_uns, p1_uns;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [31:0]       p0_wdata, p1_wdata;
  logic              p0_gnt, p1_gnt;
  logic              p0_rvalid, p1_rvalid;
  logic [31:0]       p0_rdata, p1_rdata;
  logic              p0_err, p1_err;
  logic [ADDR_W-1:0] mem_a;
  logic [3:0]        mem_wea;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  modport slave (
    input  p0_req, p0_we, p0_size, p0_uns, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_size, p1_uns, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_a, mem_wea, mem_wd,
    input  mem_rd
  );

  modport master (
    output p0_req, p0_we, p0_size, p0_uns, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_size, p1_uns, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_a, mem_wea, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_align.sv
// Combinational byte-lane handling for a 32-bit little-endian data memory.
// Store side: st_en/st_size/st_lo/st_wdata -> st_wea (lane strobes) and
//   st_wd (store data replicated into every lane it could occupy).
// Load side: ld_word/ld_lo/ld_size/ld_uns -> ld_data (selected bytes moved
//   to bit 0 and sign- or zero-extended; word loads pass through).
module dmem_align
  import dmem_arbiter_pkg::*;
(
  input  logic        st_en,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wea,
  output logic [31:0] st_wd,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  output logic [31:0] ld_data
);

  logic [3:0]  mask;
  logic [31:0] shifted;

  always_comb begin
    mask  = 4'b1111;
    st_wd = st_wdata;
    case (st_size)
      SZ_B: begin
        mask  = 4'b0001;
        st_wd = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        mask  = 4'b0011;
        st_wd = {2{st_wdata[15:0]}};
      end
      default: begin
        mask  = 4'b1111;
        st_wd = st_wdata;
      end
    endcase
    st_wea = st_en ? (mask << st_lo) : 4'b0000;
  end

  always_comb begin
    shifted = ld_word >> {ld_lo, 3'b000};
    case (ld_size)
      SZ_B:    ld_data = ld_uns ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    ld_data = ld_uns ? {16'd0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory access controller.
// Grants the single data memory to port 0 (pipeline) or port 1
// (debug/loader) each cycle, round-robin on contention, drives lane strobes
// and lane data for stores, and returns extended load data (or a store
// acknowledge) one cycle after the grant. Misaligned or out-of-range
// accesses are granted but write nothing and answer with err=1, rdata=0.
// Ports: clk, reset (synchronous, active-high), bus (dmem_arbiter_if.slave).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  function automatic logic access_bad(input logic [ADDR_W-1:0] addr,
                                      input logic [1:0]        size);
    logic [ADDR_W:0] end_excl;
    logic            bad;
    end_excl = {1'b0, addr} + (ADDR_W+1)'(size_bytes(size));
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr[0];
      SZ_W:    bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    if (end_excl > (ADDR_W+1)'(MEM_BYTES)) bad = 1'b1;
    return bad;
  endfunction

  // rr_last = port granted most recently; the other port wins a tie.
  logic              rr_last;
  logic              sel0, sel1, any, win;
  logic              w_we, w_uns, w_bad, st_en;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [3:0]        st_wea;
  logic [31:0]       st_wd, ld_data;

  logic              rsp_vld_p1, rsp_port_p1, rsp_err_p1, rsp_ld_p1;
  logic [31:0]       rd_word_p1;
  logic [1:0]        lo_p1, size_p1;
  logic              uns_p1;
  logic              rsp_live, rv0, rv1;

  always_comb begin
    sel0 = !reset && bus.p0_req && (!bus.p1_req || rr_last);
    sel1 = !reset && bus.p1_req && (!bus.p0_req || !rr_last);
    any  = sel0 | sel1;
    win  = sel1;
    if (sel1) begin
      w_we = bus.p1_we; w_size = bus.p1_size; w_uns = bus.p1_uns;
      w_addr = bus.p1_addr; w_wdata = bus.p1_wdata;
    end else begin
      w_we = bus.p0_we; w_size = bus.p0_size; w_uns = bus.p0_uns;
      w_addr = bus.p0_addr; w_wdata = bus.p0_wdata;
    end
    w_bad = access_bad(w_addr, w_size);
    st_en = any && w_we && !w_bad;
  end

  dmem_align u_align (
    .st_en    (st_en),
    .st_size  (w_size),
    .st_lo    (w_addr[1:0]),
    .st_wdata (w_wdata),
    .st_wea   (st_wea),
    .st_wd    (st_wd),
    .ld_word  (rd_word_p1),
    .ld_lo    (lo_p1),
    .ld_size  (size_p1),
    .ld_uns   (uns_p1),
    .ld_data  (ld_data)
  );

  assign bus.p0_gnt  = sel0;
  assign bus.p1_gnt  = sel1;
  assign bus.mem_a   = any ? {w_addr[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wea = st_wea;
  assign bus.mem_wd  = any ? st_wd : '0;

  // ---- grant cycle -> response cycle (p1) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last    <= 1'b1;
      rsp_vld_p1 <= 1'b0;
    end else begin
      rsp_vld_p1 <= any;
      if (any) rr_last <= win;
    end
  end

  always_ff @(posedge clk) begin
    if (any) begin
      rsp_port_p1 <= win;
      rsp_err_p1  <= w_bad;
      rsp_ld_p1   <= !w_we && !w_bad;
      rd_word_p1  <= bus.mem_rd;
      lo_p1       <= w_addr[1:0];
      size_p1     <= w_size;
      uns_p1      <= w_uns;
    end
  end

  // A response still in flight when reset rises is dropped.
  assign rsp_live = rsp_vld_p1 && !reset;
  assign rv0      = rsp_live && !rsp_port_p1;
  assign rv1      = rsp_live && rsp_port_p1;

  assign bus.p0_rvalid = rv0;
  assign bus.p1_rvalid = rv1;
  assign bus.p0_err    = rv0 && rsp_err_p1;
  assign bus.p1_err    = rv1 && rsp_err_p1;
  assign bus.p0_rdata  = (rv0 && rsp_ld_p1) ? ld_data : 32'd0;
  assign bus.p1_rdata  = (rv1 && rsp_ld_p1) ? ld_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory device: combinational read, strobed write, cleared on reset.
  logic [31:0] tmem [0:1023];
  assign bus.mem_rd = tmem[bus.mem_a[11:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) tmem[i] <= 32'd0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (bus.mem_wea[l]) tmem[bus.mem_a[11:2]][8*l +: 8] <= bus.mem_wd[8*l +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_size = size;
      bus.p0_uns = uns; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_size = size;
      bus.p1_uns = uns; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Results of the last single-port access.
  logic        c_gnt, r_vld, r_oth, r_err;
  logic [3:0]  c_wea;
  logic [31:0] c_wd, c_a, r_data;

  task automatic acc(input int p, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    drive(p, 1'b1, we, size, uns, addr, wdata);
    drive(1 - p, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    c_gnt = (p == 0) ? bus.p0_gnt : bus.p1_gnt;
    c_wea = bus.mem_wea;
    c_wd  = bus.mem_wd;
    c_a   = bus.mem_a;
    @(posedge clk);
    #1;
    r_vld  = (p == 0) ? bus.p0_rvalid : bus.p1_rvalid;
    r_oth  = (p == 0) ? bus.p1_rvalid : bus.p0_rvalid;
    r_data = (p == 0) ? bus.p0_rdata  : bus.p1_rdata;
    r_err  = (p == 0) ? bus.p0_err    : bus.p1_err;
    drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  typedef struct {
    string       name;
    int          p;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input string name, input int p, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wea, input logic [31:0] wd,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.name = name; v.p = p; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.wea = wea; v.wd = wd; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  // Reference model state for the randomized phase.
  typedef struct {
    bit          act;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic [7:0] ref_mem [0:4095];
  op_t        pend [2];
  int         m_last;

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b11) ? 0 : (1 << size);
  endfunction

  function automatic bit is_bad(input op_t o);
    int n;
    n = nbytes(o.size);
    if (n == 0) return 1'b1;
    if ((o.addr % n) != 0) return 1'b1;
    if (o.addr + n > 4096) return 1'b1;
    return 1'b0;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int n;
    o.act = 1'b1;
    o.we  = 1'($urandom_range(0, 1));
    o.uns = 1'($urandom_range(0, 1));
    o.size = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    if ($urandom_range(0, 7) == 0) o.addr = 32'hFF8 + $urandom_range(0, 7);
    else                           o.addr = 32'h100 + $urandom_range(0, 63);
    n = nbytes(o.size);
    if (n != 0 && $urandom_range(0, 3) != 0) o.addr = o.addr - (o.addr % n);
    o.wdata = $urandom;
    return o;
  endfunction

  vec_t vt[$];

  initial begin
    int          w, n;
    bit          e;
    logic [3:0]  exp_wea;
    logic [31:0] exp_rd, m;
    op_t         o;

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;

    // Reset state, with a store request present that must be ignored.
    reset = 1'b1;
    idle_all();
    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFFFFFF);
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.p0_gnt), 32'd0);
    chk("rst_wea", 32'(bus.mem_wea), 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_wd", bus.mem_wd, 32'd0);
    chk("rst_rvalid0", 32'(bus.p0_rvalid), 32'd0);
    chk("rst_rvalid1", 32'(bus.p1_rvalid), 32'd0);
    chk("rst_err0", 32'(bus.p0_err), 32'd0);
    chk("rst_rdata0", bus.p0_rdata, 32'd0);
    @(posedge clk);
    #1;
    idle_all();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_wea", 32'(bus.mem_wea), 32'd0);
    chk("idle_mem_a", bus.mem_a, 32'd0);
    chk("idle_mem_wd", bus.mem_wd, 32'd0);
    @(posedge clk);
    #1;

    // Table-driven single-port accesses.
    vt.push_back(mk("sw_10",    0, 1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0,        0));
    vt.push_back(mk("lb_13",    0, 0, 2'b00, 0, 32'h13,   32'h0,        4'h0, 32'h0,        32'hFFFFFFDE, 0));
    vt.push_back(mk("lbu_13",   0, 0, 2'b00, 1, 32'h13,   32'h0,        4'h0, 32'h0,        32'h000000DE, 0));
    vt.push_back(mk("lh_12",    0, 0, 2'b01, 0, 32'h12,   32'h0,        4'h0, 32'h0,        32'hFFFFDEAD, 0));
    vt.push_back(mk("lhu_12",   0, 0, 2'b01, 1, 32'h12,   32'h0,        4'h0, 32'h0,        32'h0000DEAD, 0));
    vt.push_back(mk("sb_21",    1, 1, 2'b00, 0, 32'h21,   32'h0000005A, 4'h2, 32'h5A5A5A5A, 32'h0,        0));
    vt.push_back(mk("lw_20",    1, 0, 2'b10, 0, 32'h20,   32'h0,        4'h0, 32'h0,        32'h00005A00, 0));
    vt.push_back(mk("sh_11",    0, 1, 2'b01, 0, 32'h11,   32'h0000FFFF, 4'h0, 32'h0,        32'h0,        1));
    vt.push_back(mk("sw_22",    0, 1, 2'b10, 0, 32'h22,   32'h12345678, 4'h0, 32'h0,        32'h0,        1));
    vt.push_back(mk("rb_10",    0, 0, 2'b10, 0, 32'h10,   32'h0,        4'h0, 32'h0,        32'hDEADBEEF, 0));
    vt.push_back(mk("rb_20",    0, 0, 2'b10, 0, 32'h20,   32'h0,        4'h0, 32'h0,        32'h00005A00, 0));
    vt.push_back(mk("sh_16",    1, 1, 2'b01, 0, 32'h16,   32'h00001234, 4'hC, 32'h12341234, 32'h0,        0));
    vt.push_back(mk("sb_17",    1, 1, 2'b00, 0, 32'h17,   32'h00000080, 4'h8, 32'h80808080, 32'h0,        0));
    vt.push_back(mk("lh_16",    0, 0, 2'b01, 0, 32'h16,   32'h0,        4'h0, 32'h0,        32'hFFFF8034, 0));
    vt.push_back(mk("lb_17",    0, 0, 2'b00, 0, 32'h17,   32'h0,        4'h0, 32'h0,        32'hFFFFFF80, 0));
    vt.push_back(mk("lw_14u",   0, 0, 2'b10, 1, 32'h14,   32'h0,        4'h0, 32'h0,        32'h80340000, 0));
    vt.push_back(mk("sz11",     0, 0, 2'b11, 0, 32'h10,   32'h0,        4'h0, 32'h0,        32'h0,        1));
    vt.push_back(mk("lw_1000",  1, 0, 2'b10, 0, 32'h1000, 32'h0,        4'h0, 32'h0,        32'h0,        1));
    vt.push_back(mk("lb_1000",  0, 0, 2'b00, 0, 32'h1000, 32'h0,        4'h0, 32'h0,        32'h0,        1));
    vt.push_back(mk("sw_ffc",   0, 1, 2'b10, 0, 32'hFFC,  32'hAAAA5555, 4'hF, 32'hAAAA5555, 32'h0,        0));
    vt.push_back(mk("lw_ffc",   1, 0, 2'b10, 0, 32'hFFC,  32'h0,        4'h0, 32'h0,        32'hAAAA5555, 0));
    vt.push_back(mk("sh_ffe",   1, 1, 2'b01, 0, 32'hFFE,  32'h0000BEEF, 4'hC, 32'hBEEFBEEF, 32'h0,        0));
    vt.push_back(mk("lhu_ffe",  0, 0, 2'b01, 1, 32'hFFE,  32'h0,        4'h0, 32'h0,        32'h0000BEEF, 0));

    foreach (vt[i]) begin
      acc(vt[i].p, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata);
      chk({vt[i].name, "_gnt"}, 32'(c_gnt), 32'd1);
      chk({vt[i].name, "_wea"}, 32'(c_wea), 32'(vt[i].wea));
      if (vt[i].we && !vt[i].err) chk({vt[i].name, "_wd"}, c_wd, vt[i].wd);
      if (!vt[i].err) chk({vt[i].name, "_mem_a"}, c_a, vt[i].addr & 32'hFFFF_FFFC);
      chk({vt[i].name, "_rvalid"}, 32'(r_vld), 32'd1);
      chk({vt[i].name, "_other_rvalid"}, 32'(r_oth), 32'd0);
      chk({vt[i].name, "_rdata"}, r_data, vt[i].rdata);
      chk({vt[i].name, "_err"}, 32'(r_err), 32'(vt[i].err));
    end

    // Six cycles of contention straight after reset: 0,1,0,1,0,1.
    do_reset();
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_gnt0", i), 32'(bus.p0_gnt), 32'((i % 2) == 0));
      chk($sformatf("rr%0d_gnt1", i), 32'(bus.p1_gnt), 32'((i % 2) == 1));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_rvalid0", i), 32'(bus.p0_rvalid), 32'((i % 2) == 0));
      chk($sformatf("rr%0d_rvalid1", i), 32'(bus.p1_rvalid), 32'((i % 2) == 1));
    end
    idle_all();

    // Reset in the cycle after a p0 grant drops the response and restores
    // port 0 as the winner of the next contention.
    do_reset();
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    @(negedge clk);
    chk("rg_gnt0", 32'(bus.p0_gnt), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_all();
    @(negedge clk);
    chk("rg_rvalid0_in_reset", 32'(bus.p0_rvalid), 32'd0);
    @(posedge clk);
    #1;
    chk("rg_rvalid0_after", 32'(bus.p0_rvalid), 32'd0);
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'd0);
    @(negedge clk);
    chk("rg_cont_gnt0", 32'(bus.p0_gnt), 32'd1);
    chk("rg_cont_gnt1", 32'(bus.p1_gnt), 32'd0);
    @(posedge clk);
    #1;
    idle_all();

    // Randomized traffic against the reference model.
    do_reset();
    m_last = 1;
    pend[0].act = 1'b0;
    pend[1].act = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].act && $urandom_range(0, 3) != 0) pend[p] = rand_op();
      for (int p = 0; p < 2; p++)
        drive(p, pend[p].act, pend[p].we, pend[p].size, pend[p].uns, pend[p].addr, pend[p].wdata);
      @(negedge clk);
      if (pend[0].act && pend[1].act) w = (m_last == 0) ? 1 : 0;
      else if (pend[0].act)           w = 0;
      else if (pend[1].act)           w = 1;
      else                            w = -1;
      chk("rnd_gnt0", 32'(bus.p0_gnt), 32'(w == 0));
      chk("rnd_gnt1", 32'(bus.p1_gnt), 32'(w == 1));
      exp_wea = 4'b0000;
      exp_rd  = 32'd0;
      e       = 1'b0;
      if (w >= 0) begin
        o = pend[w];
        e = is_bad(o);
        n = nbytes(o.size);
        if (!e) chk("rnd_mem_a", bus.mem_a, o.addr & 32'hFFFF_FFFC);
        if (!e && o.we) begin
          for (int k = 0; k < n; k++) begin
            exp_wea[(o.addr % 4) + k] = 1'b1;
            chk("rnd_wd_lane", 32'(bus.mem_wd[8*((o.addr % 4) + k) +: 8]), 32'(o.wdata[8*k +: 8]));
            ref_mem[o.addr + k] = o.wdata[8*k +: 8];
          end
        end
        if (!e && !o.we) begin
          for (int k = 0; k < n; k++) exp_rd = exp_rd | (32'(ref_mem[o.addr + k]) << (8 * k));
          if (n < 4 && !o.uns && exp_rd[8*n - 1]) begin
            m = (32'd1 << (8 * n)) - 32'd1;
            exp_rd = exp_rd | ~m;
          end
        end
        m_last = w;
        pend[w].act = 1'b0;
      end
      chk("rnd_wea", 32'(bus.mem_wea), 32'(exp_wea));
      @(posedge clk);
      #1;
      chk("rnd_rvalid0", 32'(bus.p0_rvalid), 32'(w == 0));
      chk("rnd_rvalid1", 32'(bus.p1_rvalid), 32'(w == 1));
      if (w == 0) begin
        chk("rnd_rdata0", bus.p0_rdata, exp_rd);
        chk("rnd_err0", 32'(bus.p0_err), 32'(e));
      end else if (w == 1) begin
        chk("rnd_rdata1", bus.p1_rdata, exp_rd);
        chk("rnd_err1", 32'(bus.p1_err), 32'(e));
      end
    end
    idle_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port access controller sitting between the pipeline's memory stage, a debug/loader port, and the single byte-addressed data memory. It grants the memory to one requester per cycle (round-robin on contention), generates the 4-bit byte-write strobe and aligned write data from access size and address, and returns aligned, sign- or zero-extended load data one cycle after grant. Misaligned accesses are suppressed and flagged.

## Interface
- ADDR_W, 32, address width (equals XLEN)
- MEM_BYTES, 4096, memory size in bytes; addresses ≥ MEM_BYTES flag an error
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Per port p ∈ {0,1} (0 = pipeline, 1 = debug/loader):
- pP_req  in  1  access request, held until granted
- pP_we  in  1  1 = store, 0 = load
- pP_size  in  2  00 byte, 01 half, 10 word (11 treated as misaligned)
- pP_uns  in  1  load zero-extend when 1, sign-extend when 0
- pP_addr  in  ADDR_W  byte address
- pP_wdata  in  32  store data, right-justified
- pP_gnt  out  1  request accepted this cycle (combinational)
- pP_rvalid  out  1  response valid, cycle after grant
- pP_rdata  out  32  extended load data (0 for stores and errors)
- pP_err  out  1  misaligned/out-of-range, qualified by pP_rvalid
- mem_a  out  ADDR_W  word-aligned address to memory (addr[1:0] forced 00)
- mem_wea  out  4  byte-lane write strobes
- mem_wd  out  32  lane-positioned write data
- mem_rd  in  32  combinational read data for mem_a

## Operation
- Arbitration: only one requester → it wins. Both → winner is port not granted most recently (rr_last flop). rr_last updates only on a grant.
- Reset: rr_last = 1 (port 0 wins first contention); all gnt, rvalid, err, mem_wea = 0; rdata = 0; mem_a/mem_wd = 0 while reset is high. Reset asserted during a pending response discards it (rvalid stays 0).
- No request: mem_wea = 0, mem_a/mem_wd hold 0.
- Alignment check: half needs addr[0]=0; word needs addr[1:0]=00; size 11 always bad; addr+bytes > MEM_BYTES bad. Bad access: still granted (consumes the cycle), mem_wea = 0, next cycle rvalid=1, err=1, rdata=0.
- Store: mask = 0001/0011/1111 by size, mem_wea = mask << addr[1:0]; mem_wd = wdata replicated into lanes (byte ×4, half ×2, word as-is).
- Load: captured word shifted right by 8·addr[1:0], truncated to size, extended per uns. Word loads ignore uns.
- Stores also produce rvalid (err=0, rdata=0) as completion acknowledge.

## Timing
- Cycle N: req high, gnt high combinationally, mem_* driven from winner; store lands in memory on edge ending N.
- Edge ending N: mem_rd, addr[1:0], size, uns, err, port id registered.
- Cycle N+1: winner's rvalid=1 with rdata/err; other port's rvalid=0. Throughput 1 access/cycle total; back-to-back grants to either port allowed.
- Load in N+1 to address stored in N returns new data.
- Loser keeps req high; guaranteed grant within 2 cycles.

## Structure
- Size encodings (SZ_B, SZ_H, SZ_W) and MEM_BYTES default belong in the shared xgriscv defines file.
- One sub-module: dmem_align — combinational store lane/strobe generation and load shift/extend, reused by the pipeline if needed.
- Arbiter, response register and rr_last stay in dmem_arbiter.

## Test plan
- Reset then p0 sw addr 0x10 wdata 0xDEADBEEF → mem_wea=1111, mem_a=0x10; next cycle p0_rvalid=1, err=0.
- p0 lb addr 0x13 after above (uns=0) → p0_rdata=0xFFFFFFDE; lbu → 0x000000DE; lh addr 0x12 → 0xFFFFDEAD.
- p1 sb addr 0x21 wdata 0x5A → mem_wea=0010, mem_wd=0x5A5A5A5A; p1 lw 0x20 shows byte1=0x5A only.
- Both req every cycle for 6 cycles, starting after reset → grants alternate 0,1,0,1,0,1; each rvalid on matching port one cycle later.
- p0 sh addr 0x11 and sw addr 0x22 → mem_wea=0000, rvalid with err=1, rdata=0; memory unchanged on readback.
- Reset asserted in cycle after a grant → rvalid stays 0, next contention grants p0 first.
